// File: rtl/seq_mult_16.sv
// seq_mult_16: 16x16 unsigned shift-add multiplier, 32-bit product.
// Borrows the shared external Adder_16 for every partial-product step.
module seq_mult_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] A_in16,
    input  logic [15:0] B_in16,
    output logic        busy,
    output logic        done,
    output logic [31:0] Product_out32,
    output logic [15:0] Add_A_out16,
    output logic [15:0] Add_B_out16,
    output logic        Add_Carry_out,
    input  logic [15:0] Add_Sum_in16,
    input  logic        Add_Carry_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] mcand;
    logic [31:0] p;
    logic [3:0]  cnt;
    logic [31:0] p_step;
    logic        last_step;

    // Adder result re-enters the top half; carry-out becomes the new MSB.
    assign p_step    = {Add_Carry_in, Add_Sum_in16, p[15:1]};
    assign last_step = (cnt == 4'd15);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status and adder-drive outputs, decoded from state and registers
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        Add_A_out16   = 16'h0000;
        Add_B_out16   = 16'h0000;
        Add_Carry_out = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            RUN: begin
                busy        = 1'b1;
                Add_A_out16 = p[31:16];
                Add_B_out16 = p[0] ? mcand : 16'h0000;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Operand capture, shift-add steps and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= 16'h0000;
            p     <= 32'h0000_0000;
            cnt   <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A_in16;
                        p     <= {16'h0000, B_in16};
                        cnt   <= 4'd0;
                    end
                end
                RUN: begin
                    p   <= p_step;
                    cnt <= cnt + 4'd1;
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    // Result register: updated only as the final step completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Product_out32 <= 32'h0000_0000;
        end else if (state == RUN && last_step) begin
            Product_out32 <= p_step;
        end
    end

endmodule

// File: tb/tb_seq_mult_16.sv
// tb_seq_mult_16: directed bench for seq_mult_16.
// Models Adder_16 combinationally and checks with immediate assertions.
module tb_seq_mult_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [31:0] prod;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cout;
    logic [15:0] add_sum;
    logic        add_cin;

    int          checks;
    int          errors;
    logic [31:0] last_exp;
    logic [15:0] last_bor;

    seq_mult_16 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .A_in16        (A),
        .B_in16        (B),
        .busy          (busy),
        .done          (done),
        .Product_out32 (prod),
        .Add_A_out16   (add_a),
        .Add_B_out16   (add_b),
        .Add_Carry_out (add_cout),
        .Add_Sum_in16  (add_sum),
        .Add_Carry_in  (add_cin)
    );

    // Behavioural stand-in for the ripple-carry Adder_16
    assign {add_cin, add_sum} = {1'b0, add_a} + {1'b0, add_b}
                              + {16'h0000, add_cout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [31:0] exp,
                         input string tag);
        int n;
        int nb;
        logic [15:0] bor;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = 16'hA5A5;
        B = 16'h5A5A;
        n = 0;
        nb = 0;
        bor = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            bor |= add_b;
            if (n == 8) check({tag, "_hold"}, prod, last_exp);
            if (done) break;
        end
        check({tag, "_lat"}, n, 17);
        check({tag, "_busy"}, nb, 17);
        check({tag, "_prod"}, prod, exp);
        check({tag, "_cout"}, {31'd0, add_cout}, 32'd0);
        @(negedge clk);
        check({tag, "_done1"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        last_exp = exp;
        last_bor = bor;
    endtask

    initial begin
        int n;
        int dones;
        checks = 0;
        errors = 0;
        last_exp = 32'd0;
        last_bor = 16'd0;
        rst_n = 1'b0;
        start = 1'b0;
        A = 16'd0;
        B = 16'd0;

        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_prod", prod, 32'd0);
        check("rst_adda", {16'd0, add_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'd3, 16'd5, 32'h0000_000F, "m3x5");

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_prod", prod, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_done", {31'd0, done}, 32'd0);
        last_exp = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "mffff");
        do_op(16'h1234, 16'h0000, 32'd0, "m1234x0");
        check("m1234x0_addb", {16'd0, last_bor}, 32'd0);
        do_op(16'h0000, 16'hBEEF, 32'd0, "m0xbeef");

        // Extra starts during RUN and DONE are ignored
        @(negedge clk);
        A = 16'd7;
        B = 16'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                start = 1'b1;
                A = 16'd2;
                B = 16'd2;
            end else if (n == 6) begin
                start = 1'b0;
            end
            if (done) break;
        end
        check("m7x9_lat", n, 17);
        check("m7x9_prod", prod, 32'h0000_003F);
        start = 1'b1;
        @(negedge clk);
        check("m7x9_ign_busy", {31'd0, busy}, 32'd0);
        check("m7x9_ign_prod", prod, 32'h0000_003F);
        @(negedge clk);
        check("held_start", {31'd0, busy}, 32'd1);
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        check("m2x2_lat", n, 16);
        check("m2x2_prod", prod, 32'd4);
        @(negedge clk);
        last_exp = 32'd4;

        // Abort mid-run with reset
        @(negedge clk);
        A = 16'd100;
        B = 16'd200;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_prod", prod, 32'd0);
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_nodone", dones, 0);
        rst_n = 1'b1;
        last_exp = 32'd0;
        do_op(16'd2, 16'd3, 32'd6, "m2x3");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
